// File: rtl/vtg_pattern.sv
// ---------------------------------------------------------------------------
// vtg_pattern : video timing generator with built-in test patterns
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vtg_pattern #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23,
    parameter int HS_POL   = 1,
    parameter int VS_POL   = 1,
    parameter int CW       = 4,
    parameter int NBARS    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_en,
    input  logic [1:0]        mode,
    input  logic [3*CW-1:0]   solid_rgb,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic [CW-1:0]     red,
    output logic [CW-1:0]     green,
    output logic [CW-1:0]     blue,
    output logic [11:0]       x,
    output logic [10:0]       y,
    output logic              sof
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] C_H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [10:0] C_V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [11:0] C_H_ACT    = 12'(H_ACTIVE);
    localparam logic [10:0] C_V_ACT    = 11'(V_ACTIVE);
    localparam logic [11:0] C_HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] C_HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] C_VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] C_VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] C_BW_LAST  = 12'(H_ACTIVE / NBARS - 1);
    localparam logic [11:0] C_BAR_LAST = 12'(NBARS - 1);
    localparam logic        C_HS_ACT   = 1'(HS_POL);
    localparam logic        C_VS_ACT   = 1'(VS_POL);

    logic [11:0]      hcnt_q, hcnt_d;
    logic [10:0]      vcnt_q, vcnt_d;
    logic [11:0]      bar_q, bar_d;
    logic [11:0]      bpos_q, bpos_d;
    logic [1:0]       mode_q, mode_d;
    logic [3*CW-1:0]  solid_q, solid_d;
    logic             hs_q, hs_d, vs_q, vs_d, de_q, de_d, sof_q, sof_d;
    logic [3*CW-1:0]  rgb_q, rgb_d;
    logic [11:0]      x_q, x_d;
    logic [10:0]      y_q, y_d;

    logic             h_wrap, frame_start, active;
    logic [2:0]       bar_code;

    always_comb begin
        h_wrap      = (hcnt_q == C_H_LAST);
        frame_start = (hcnt_q == 12'd0) && (vcnt_q == 11'd0);
        active      = (hcnt_q < C_H_ACT) && (vcnt_q < C_V_ACT);

        hcnt_d = hcnt_q + 12'd1;
        vcnt_d = vcnt_q;
        if (h_wrap) begin
            hcnt_d = 12'd0;
            vcnt_d = (vcnt_q == C_V_LAST) ? 11'd0 : vcnt_q + 11'd1;
        end

        // Bar tracking: the last bar never advances, so remainder pixels widen it.
        bar_d  = bar_q;
        bpos_d = bpos_q;
        if (h_wrap) begin
            bar_d  = 12'd0;
            bpos_d = 12'd0;
        end else if (bar_q != C_BAR_LAST) begin
            if (bpos_q == C_BW_LAST) begin
                bar_d  = bar_q + 12'd1;
                bpos_d = 12'd0;
            end else begin
                bpos_d = bpos_q + 12'd1;
            end
        end

        // The frame's first pixel already uses the freshly sampled selection.
        mode_d  = frame_start ? mode      : mode_q;
        solid_d = frame_start ? solid_rgb : solid_q;

        hs_d  = (hcnt_q >= C_HS_START && hcnt_q < C_HS_END) ? C_HS_ACT : ~C_HS_ACT;
        vs_d  = (vcnt_q >= C_VS_START && vcnt_q < C_VS_END) ? C_VS_ACT : ~C_VS_ACT;
        de_d  = active;
        sof_d = frame_start;
        x_d   = active ? hcnt_q : x_q;
        y_d   = active ? vcnt_q : y_q;

        bar_code = ~bar_q[2:0];
        rgb_d    = '0;
        if (active) begin
            case (mode_d)
                2'd0:    rgb_d = {{CW{bar_code[2]}}, {CW{bar_code[1]}}, {CW{bar_code[0]}}};
                2'd1:    rgb_d = (hcnt_q[4] ^ vcnt_q[4]) ? {3*CW{1'b1}} : '0;
                2'd2:    rgb_d = {3{hcnt_q[CW+3:4]}};
                default: rgb_d = solid_d;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            bar_q   <= '0;
            bpos_q  <= '0;
            mode_q  <= '0;
            solid_q <= '0;
            hs_q    <= ~C_HS_ACT;
            vs_q    <= ~C_VS_ACT;
            de_q    <= 1'b0;
            sof_q   <= 1'b0;
            rgb_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else if (pix_en) begin
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            bar_q   <= bar_d;
            bpos_q  <= bpos_d;
            mode_q  <= mode_d;
            solid_q <= solid_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            sof_q   <= sof_d;
            rgb_q   <= rgb_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign hsync = hs_q;
    assign vsync = vs_q;
    assign de    = de_q;
    assign sof   = sof_q;
    assign red   = rgb_q[3*CW-1:2*CW];
    assign green = rgb_q[2*CW-1:CW];
    assign blue  = rgb_q[CW-1:0];
    assign x     = x_q;
    assign y     = y_q;

endmodule

`default_nettype wire

// File: tb/tb_vtg_pattern.sv
// ---------------------------------------------------------------------------
// tb_vtg_pattern : three parameterisations of vtg_pattern against a reference model
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_vtg_pattern;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic        sof;
        logic [11:0] rgb;
        logic [11:0] x;
        logic [10:0] y;
    } out_t;

    typedef struct {
        logic [1:0]  mode;
        logic [11:0] solid;
        int          d;
        int          h;
        int          v;
        logic [11:0] rgb;
    } vec_t;

    localparam int P_HA  [3] = '{8, 10, 48};
    localparam int P_HF  [3] = '{2, 2, 4};
    localparam int P_HS  [3] = '{3, 3, 4};
    localparam int P_HB  [3] = '{3, 3, 8};
    localparam int P_VA  [3] = '{4, 4, 40};
    localparam int P_VF  [3] = '{1, 1, 1};
    localparam int P_VS  [3] = '{2, 2, 2};
    localparam int P_VB  [3] = '{1, 1, 1};
    localparam int P_POL [3] = '{1, 0, 1};
    localparam int P_NB  [3] = '{4, 4, 8};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_en;
    logic [1:0]  mode;
    logic [11:0] solid_rgb;

    logic        hs [3];
    logic        vs [3];
    logic        de_o [3];
    logic        sof_o [3];
    logic [3:0]  r [3];
    logic [3:0]  g [3];
    logic [3:0]  b [3];
    logic [11:0] xo [3];
    logic [10:0] yo [3];

    int total = 0;
    int bad   = 0;

    int          mh [3];
    int          mv [3];
    logic [1:0]  lm [3];
    logic [11:0] ls [3];
    logic [11:0] lx [3];
    logic [10:0] ly [3];
    out_t        held [3];
    out_t        exp_q [$];

    int          tgt_d = -1;
    int          tgt_h, tgt_v;
    logic [11:0] tgt_rgb;
    logic        tgt_hit = 1'b0;
    logic        tgt_done = 1'b0;
    string       tgt_name;

    always #5 clk = ~clk;

    vtg_pattern #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1),
                  .V_SYNC(2), .V_BP(1), .HS_POL(1), .VS_POL(1), .CW(4), .NBARS(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .mode(mode), .solid_rgb(solid_rgb),
        .hsync(hs[0]), .vsync(vs[0]), .de(de_o[0]), .red(r[0]), .green(g[0]), .blue(b[0]),
        .x(xo[0]), .y(yo[0]), .sof(sof_o[0]));

    vtg_pattern #(.H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1),
                  .V_SYNC(2), .V_BP(1), .HS_POL(0), .VS_POL(0), .CW(4), .NBARS(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .mode(mode), .solid_rgb(solid_rgb),
        .hsync(hs[1]), .vsync(vs[1]), .de(de_o[1]), .red(r[1]), .green(g[1]), .blue(b[1]),
        .x(xo[1]), .y(yo[1]), .sof(sof_o[1]));

    vtg_pattern #(.H_ACTIVE(48), .H_FP(4), .H_SYNC(4), .H_BP(8), .V_ACTIVE(40), .V_FP(1),
                  .V_SYNC(2), .V_BP(1), .HS_POL(1), .VS_POL(1), .CW(4), .NBARS(8)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .mode(mode), .solid_rgb(solid_rgb),
        .hsync(hs[2]), .vsync(vs[2]), .de(de_o[2]), .red(r[2]), .green(g[2]), .blue(b[2]),
        .x(xo[2]), .y(yo[2]), .sof(sof_o[2]));

    function automatic out_t actual(input int d);
        out_t a;
        a.hs  = hs[d];
        a.vs  = vs[d];
        a.de  = de_o[d];
        a.sof = sof_o[d];
        a.rgb = {r[d], g[d], b[d]};
        a.x   = xo[d];
        a.y   = yo[d];
        return a;
    endfunction

    function automatic out_t reset_out(input int d);
        out_t e;
        e     = '0;
        e.hs  = (P_POL[d] == 0);
        e.vs  = (P_POL[d] == 0);
        return e;
    endfunction

    task automatic check(input int d, input out_t e, input string nm);
        out_t a;
        a = actual(d);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s dut%0d @%0t: got hs=%b vs=%b de=%b sof=%b rgb=%h x=%0d y=%0d, want hs=%b vs=%b de=%b sof=%b rgb=%h x=%0d y=%0d",
                     nm, d, $time, a.hs, a.vs, a.de, a.sof, a.rgb, a.x, a.y,
                     e.hs, e.vs, e.de, e.sof, e.rgb, e.x, e.y);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    // Reference model: one output record per pixel-enable tick.
    task automatic push_exp(input int d);
        out_t e;
        int hs0, vs0, bw, bi;
        logic [2:0] c;
        logic [3:0] gr;
        if (mh[d] == 0 && mv[d] == 0) begin
            lm[d] = mode;
            ls[d] = solid_rgb;
        end
        hs0   = P_HA[d] + P_HF[d];
        vs0   = P_VA[d] + P_VF[d];
        e.de  = (mh[d] < P_HA[d]) && (mv[d] < P_VA[d]);
        e.hs  = (mh[d] >= hs0 && mh[d] < hs0 + P_HS[d]) ? (P_POL[d] != 0) : (P_POL[d] == 0);
        e.vs  = (mv[d] >= vs0 && mv[d] < vs0 + P_VS[d]) ? (P_POL[d] != 0) : (P_POL[d] == 0);
        e.sof = (mh[d] == 0 && mv[d] == 0);
        if (e.de) begin
            lx[d] = 12'(mh[d]);
            ly[d] = 11'(mv[d]);
        end
        e.x   = lx[d];
        e.y   = ly[d];
        e.rgb = 12'h000;
        if (e.de) begin
            case (lm[d])
                2'd0: begin
                    bw = P_HA[d] / P_NB[d];
                    bi = mh[d] / bw;
                    if (bi > P_NB[d] - 1) bi = P_NB[d] - 1;
                    c = 3'(7 - (bi % 8));
                    e.rgb = {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}};
                end
                2'd1: e.rgb = ((((mh[d] >> 4) ^ (mv[d] >> 4)) & 1) != 0) ? 12'hFFF : 12'h000;
                2'd2: begin
                    gr = 4'((mh[d] >> 4) & 15);
                    e.rgb = {gr, gr, gr};
                end
                default: e.rgb = ls[d];
            endcase
        end
        if (d == tgt_d && mh[d] == tgt_h && mv[d] == tgt_v) tgt_hit = 1'b1;
        exp_q.push_back(e);
        held[d] = e;
        mh[d]++;
        if (mh[d] == P_HA[d] + P_HF[d] + P_HS[d] + P_HB[d]) begin
            mh[d] = 0;
            mv[d] = (mv[d] == P_VA[d] + P_VF[d] + P_VS[d] + P_VB[d] - 1) ? 0 : mv[d] + 1;
        end
    endtask

    task automatic tick(input logic pe);
        out_t e;
        pix_en = pe;
        if (pe) for (int d = 0; d < 3; d++) push_exp(d);
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            if (pe) begin
                e = exp_q.pop_front();
                check(d, e, "scoreboard");
            end else begin
                check(d, held[d], "hold");
            end
        end
        if (tgt_hit) begin
            tgt_hit  = 1'b0;
            tgt_done = 1'b1;
            check_int(tgt_name, int'({r[tgt_d], g[tgt_d], b[tgt_d]}), int'(tgt_rgb));
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #2;
        for (int d = 0; d < 3; d++) begin
            mh[d] = 0; mv[d] = 0; lm[d] = '0; ls[d] = '0; lx[d] = '0; ly[d] = '0;
            held[d] = reset_out(d);
            check(d, held[d], "async_reset");
        end
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_to(input int d, input int h, input int v, input logic [11:0] rgb,
                          input string nm);
        int n;
        tgt_d = d; tgt_h = h; tgt_v = v; tgt_rgb = rgb; tgt_name = nm;
        tgt_done = 1'b0;
        n = 0;
        while (!tgt_done && n < 6000) begin
            tick(1'b1);
            n++;
        end
        if (!tgt_done) check_int({nm, "_timeout"}, 0, 1);
        tgt_d = -1;
    endtask

    task automatic wait_frame(input int d);
        int n;
        n = 0;
        while (!(mh[d] == 0 && mv[d] == 0) && n < 6000) begin
            tick(1'b1);
            n++;
        end
        if (n >= 6000) check_int("wait_frame_timeout", 0, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [12];
        int   nsof, nrise;
        logic prev_hs;

        vecs[0]  = '{2'd0, 12'h000, 0, 2,  1,  12'hFF0};
        vecs[1]  = '{2'd0, 12'h000, 0, 6,  0,  12'hF00};
        vecs[2]  = '{2'd0, 12'h000, 0, 9,  0,  12'h000};
        vecs[3]  = '{2'd3, 12'h5A3, 0, 3,  2,  12'h5A3};
        vecs[4]  = '{2'd0, 12'h000, 1, 9,  3,  12'hF00};
        vecs[5]  = '{2'd0, 12'h000, 1, 6,  0,  12'hF00};
        vecs[6]  = '{2'd0, 12'h000, 1, 5,  0,  12'hF0F};
        vecs[7]  = '{2'd0, 12'h000, 2, 36, 1,  12'h00F};
        vecs[8]  = '{2'd1, 12'h000, 2, 20, 3,  12'hFFF};
        vecs[9]  = '{2'd1, 12'h000, 2, 20, 20, 12'h000};
        vecs[10] = '{2'd2, 12'h000, 2, 33, 0,  12'h222};
        vecs[11] = '{2'd2, 12'h000, 2, 47, 39, 12'h222};

        rst_n     = 1'b1;
        pix_en    = 1'b0;
        mode      = 2'd0;
        solid_rgb = 12'h000;
        #1;
        apply_reset();

        tick(1'b1);
        check_int("first_tick_sof", int'(sof_o[0]), 1);
        check_int("first_tick_de", int'(de_o[0]), 1);

        // Frame/line cadence on the small instance.
        nsof = 0; nrise = 0; prev_hs = hs[0];
        for (int i = 0; i < 256; i++) begin
            tick(1'b1);
            if (sof_o[0]) nsof++;
            if (hs[0] && !prev_hs) nrise++;
            prev_hs = hs[0];
        end
        check_int("sof_per_256", nsof, 2);
        check_int("hsync_rises_per_256", nrise, 16);

        // Half-rate pixel enable: 16 ticks per line become 32 clocks.
        nrise = 0; prev_hs = hs[0];
        for (int i = 0; i < 128; i++) begin
            tick(i[0] == 1'b0);
            if (hs[0] && !prev_hs) nrise++;
            prev_hs = hs[0];
        end
        check_int("hsync_rises_half_rate", nrise, 4);

        // Mid-frame mode change: bars persist until the next frame.
        wait_frame(0);
        mode = 2'd0;
        run_to(0, 4, 0, 12'hF0F, "bars_before_change");
        mode = 2'd3;
        solid_rgb = 12'h5A3;
        run_to(0, 0, 2, 12'hFFF, "bars_after_change");
        run_to(0, 4, 1, 12'h5A3, "solid_next_frame");

        // Reset pulsed mid-line restarts timing at sof.
        mode = 2'd0;
        for (int i = 0; i < 5; i++) tick(1'b1);
        apply_reset();
        tick(1'b1);
        check_int("reset_restart_sof", int'(sof_o[1]), 1);
        for (int i = 0; i < 20; i++) tick(1'b1);

        for (int i = 0; i < 12; i++) begin
            mode      = vecs[i].mode;
            solid_rgb = vecs[i].solid;
            wait_frame(vecs[i].d);
            run_to(vecs[i].d, vecs[i].h, vecs[i].v, vecs[i].rgb, $sformatf("vec%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
